// File: rtl/block_pos_gen_if.sv
// Handshake bundle between the control FSM, block_pos_gen and the draw datapath.
// Strobes and configuration in, coordinates, colour and lock capture out.
interface block_pos_gen_if #(
   parameter int X_W     = 8,
   parameter int Y_W     = 7,
   parameter int LEVEL_W = 6,
   parameter int SPEED_W = 4
);
   logic               ld_x;
   logic               ld_y;
   logic               restart;
   logic               lock;
   logic [LEVEL_W-1:0] curr_level;
   logic [SPEED_W-1:0] speed;
   logic [3:0]         blk_cells;
   logic [2:0]         colour_in;
   logic               colour_erase_enable;
   logic [X_W-1:0]     x;
   logic [Y_W-1:0]     y;
   logic [2:0]         colour;
   logic               dir;
   logic               moved;
   logic [X_W-1:0]     locked_x;
   logic               locked_valid;

   modport master (
      output ld_x, ld_y, restart, lock, curr_level, speed,
      output blk_cells, colour_in, colour_erase_enable,
      input  x, y, colour, dir, moved, locked_x, locked_valid
   );

   modport slave (
      input  ld_x, ld_y, restart, lock, curr_level, speed,
      input  blk_cells, colour_in, colour_erase_enable,
      output x, y, colour, dir, moved, locked_x, locked_valid
   );
endinterface

// File: rtl/block_pos_gen.sv
// Moving-block position generator: bouncing x, level-derived y, lock capture.
// Define BLOCK_POS_RANDOM_START_EN for an LFSR-randomised restart position.
module block_pos_gen #(
   parameter int X_W     = 8,
   parameter int Y_W     = 7,
   parameter int LEVEL_W = 6,
   parameter int SPEED_W = 4,
   parameter int STEP    = 4,
   parameter int X_LIMIT = 156,
   parameter int Y_BASE  = 116
) (
   input logic          clk,
   input logic          reset,
   block_pos_gen_if.slave bus
);
   localparam int XW4 = X_W + 4;
   localparam int YSW = Y_W + LEVEL_W + 2;

   logic [X_W-1:0]     r_x;
   logic [Y_W-1:0]     r_y;
   logic               r_dir;
   logic [SPEED_W-1:0] r_pre;
   logic               r_moved;
   logic [X_W-1:0]     r_locked_x;
   logic               r_locked_valid;

   logic [X_W-1:0]     w_x_nxt;
   logic               w_dir_nxt;
   logic [SPEED_W-1:0] w_pre_nxt;
   logic               w_moved_nxt;
   logic [Y_W-1:0]     w_y_ld;

   logic [XW4-1:0]     w_cells;
   logic [XW4-1:0]     w_sub;
   logic [X_W-1:0]     w_lim;
   logic [YSW-1:0]     w_ydec;
   logic [X_W-1:0]     w_start_x;
   logic               w_start_dir;

   // Right limit shrinks as the block widens so its right edge stays on screen
   always_comb begin
      w_cells = (bus.blk_cells == 4'd0) ? XW4'(1) : XW4'(bus.blk_cells);
      w_sub   = (w_cells - XW4'(1)) * XW4'(STEP);
      w_lim   = (w_sub > XW4'(X_LIMIT)) ? '0
              : X_W'(XW4'(X_LIMIT) - w_sub);
   end

   always_comb begin
      w_ydec = YSW'(STEP) * YSW'(bus.curr_level);
      w_y_ld = (w_ydec > YSW'(Y_BASE)) ? '0
             : Y_W'(YSW'(Y_BASE) - w_ydec);
   end

`ifdef BLOCK_POS_RANDOM_START_EN
   logic [7:0]     r_lfsr;
   logic           w_lfsr_fb;
   logic [XW4-1:0] w_slots;
   logic [XW4-1:0] w_slot;

   assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_lfsr <= 8'hA5;
      else       r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
   end

   always_comb begin
      w_slots     = XW4'(w_lim) / XW4'(STEP) + XW4'(1);
      w_slot      = XW4'(r_lfsr) % w_slots;
      w_start_x   = X_W'(w_slot * XW4'(STEP));
      w_start_dir = r_lfsr[0];
   end
`else
   assign w_start_x   = '0;
   assign w_start_dir = 1'b1;
`endif

   always_comb begin
      w_x_nxt     = r_x;
      w_dir_nxt   = r_dir;
      w_pre_nxt   = r_pre;
      w_moved_nxt = 1'b0;
      if (bus.restart) begin
         w_x_nxt   = w_start_x;
         w_dir_nxt = w_start_dir;
         w_pre_nxt = '0;
      end else if (bus.ld_x) begin
         if (r_pre == bus.speed) begin
            w_pre_nxt = '0;
            if (w_lim < X_W'(STEP)) begin
               w_x_nxt = '0;
            end else if (r_dir) begin
               if (r_x >= w_lim) begin
                  w_dir_nxt = 1'b0;
                  w_x_nxt   = w_lim - X_W'(STEP);
               end else begin
                  w_x_nxt = r_x + X_W'(STEP);
               end
            end else begin
               if (r_x == '0) begin
                  w_dir_nxt = 1'b1;
                  w_x_nxt   = X_W'(STEP);
               end else begin
                  w_x_nxt = r_x - X_W'(STEP);
               end
            end
            w_moved_nxt = (w_x_nxt != r_x);
         end else begin
            w_pre_nxt = r_pre + SPEED_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x     <= '0;
         r_dir   <= 1'b1;
         r_pre   <= '0;
         r_moved <= 1'b0;
      end else begin
         r_x     <= w_x_nxt;
         r_dir   <= w_dir_nxt;
         r_pre   <= w_pre_nxt;
         r_moved <= w_moved_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         r_y <= Y_W'(Y_BASE);
      else if (bus.ld_y) r_y <= w_y_ld;
   end

   // Capture uses the pre-update x so a coincident move or restart is ignored
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_locked_x     <= '0;
         r_locked_valid <= 1'b0;
      end else begin
         r_locked_valid <= bus.lock;
         if (bus.lock) r_locked_x <= r_x;
      end
   end

   assign bus.x            = r_x;
   assign bus.y            = r_y;
   assign bus.dir          = r_dir;
   assign bus.moved        = r_moved;
   assign bus.locked_x     = r_locked_x;
   assign bus.locked_valid = r_locked_valid;
   assign bus.colour       = bus.colour_erase_enable ? 3'b000 : bus.colour_in;
endmodule

// File: tb/tb_block_pos_gen.sv
// Randomised and directed bench for block_pos_gen against a rule-level model.
// Targets the default build (random restart start disabled).
module tb_block_pos_gen;
   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_moved = 0;

   int m_x, m_y, m_dir, m_pre, m_moved, m_lx, m_lv;

   always #5 clk = ~clk;

   block_pos_gen_if #(.X_W(8), .Y_W(7), .LEVEL_W(6), .SPEED_W(4)) bus ();

   block_pos_gen #(
      .X_W(8), .Y_W(7), .LEVEL_W(6), .SPEED_W(4),
      .STEP(4), .X_LIMIT(156), .Y_BASE(116)
   ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_x = 0; m_y = 116; m_dir = 1; m_pre = 0;
      m_moved = 0; m_lx = 0; m_lv = 0;
   endtask

   task automatic model_clk();
      int cells, lim, nx;
      m_lv = int'(bus.lock);
      if (bus.lock) m_lx = m_x;
      m_moved = 0;
      cells = (bus.blk_cells == 0) ? 1 : int'(bus.blk_cells);
      lim = 156 - (cells - 1) * 4;
      if (lim < 0) lim = 0;
      if (bus.restart) begin
         m_x = 0; m_dir = 1; m_pre = 0;
      end else if (bus.ld_x) begin
         if (m_pre == int'(bus.speed)) begin
            m_pre = 0;
            nx = m_x;
            if (lim < 4) nx = 0;
            else if (m_dir == 1) begin
               if (m_x >= lim) begin m_dir = 0; nx = lim - 4; end
               else nx = m_x + 4;
            end else begin
               if (m_x == 0) begin m_dir = 1; nx = 4; end
               else nx = m_x - 4;
            end
            m_moved = (nx != m_x) ? 1 : 0;
            m_x = nx;
         end else begin
            m_pre = (m_pre + 1) % 16;
         end
      end
      if (bus.ld_y) begin
         m_y = 116 - 4 * int'(bus.curr_level);
         if (m_y < 0) m_y = 0;
      end
   endtask

   task automatic cmp_all();
      chk("x", int'(bus.x), m_x);
      chk("y", int'(bus.y), m_y);
      chk("dir", int'(bus.dir), m_dir);
      chk("moved", int'(bus.moved), m_moved);
      chk("lvalid", int'(bus.locked_valid), m_lv);
      chk("lx", int'(bus.locked_x), m_lx);
      chk("colour", int'(bus.colour),
          bus.colour_erase_enable ? 0 : int'(bus.colour_in));
   endtask

   task automatic tick();
      @(posedge clk);
      model_clk();
      #1;
      cmp_all();
      if (bus.moved) n_moved++;
   endtask

   task automatic strobes_off();
      bus.ld_x = 0; bus.ld_y = 0; bus.restart = 0; bus.lock = 0;
   endtask

   task automatic pulses(input int n);
      bus.ld_x = 1;
      repeat (n) tick();
      bus.ld_x = 0;
   endtask

   initial begin
      reset = 1'b1;
      strobes_off();
      bus.curr_level = '0;
      bus.speed = '0;
      bus.blk_cells = 4'd1;
      bus.colour_in = 3'd5;
      bus.colour_erase_enable = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      cmp_all();
      reset = 1'b0;

      // full sweep to the right wall and one bounce
      n_moved = 0;
      pulses(39);
      chk("sweep_top_x", int'(bus.x), 156);
      chk("sweep_top_dir", int'(bus.dir), 1);
      pulses(1);
      chk("bounce_x", int'(bus.x), 152);
      chk("bounce_dir", int'(bus.dir), 0);
      chk("sweep_moves", n_moved, 40);

      // prescaler: speed=2 moves once every three strobes
      bus.restart = 1; bus.speed = 4'd2;
      tick();
      bus.restart = 0;
      n_moved = 0;
      bus.ld_x = 1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         chk("presc_x", int'(bus.x), (k / 3) * 4);
      end
      bus.ld_x = 0;
      chk("presc_moves", n_moved, 3);

      // block widens while parked on the right wall
      bus.restart = 1; bus.speed = 4'd0;
      tick();
      bus.restart = 0;
      pulses(39);
      chk("wide_pre_x", int'(bus.x), 156);
      bus.blk_cells = 4'd4;
      pulses(1);
      chk("wide_x", int'(bus.x), 140);
      chk("wide_dir", int'(bus.dir), 0);
      bus.blk_cells = 4'd1;

      // row y loads and saturation
      bus.ld_y = 1; bus.curr_level = 6'd5;
      tick();
      chk("y_lvl5", int'(bus.y), 96);
      bus.curr_level = 6'd40;
      tick();
      chk("y_sat", int'(bus.y), 0);
      bus.ld_y = 0;

      // lock coinciding with a move
      bus.restart = 1;
      tick();
      bus.restart = 0;
      pulses(5);
      bus.lock = 1; bus.ld_x = 1;
      tick();
      chk("lock_x", int'(bus.locked_x), 20);
      chk("lock_newx", int'(bus.x), 24);
      chk("lock_valid", int'(bus.locked_valid), 1);
      bus.lock = 0; bus.ld_x = 0;
      tick();
      chk("lock_valid_drop", int'(bus.locked_valid), 0);
      bus.lock = 1;
      repeat (2) tick();
      chk("lock_b2b", int'(bus.locked_valid), 1);
      bus.lock = 1; bus.restart = 1; bus.ld_x = 1;
      tick();
      chk("rst_lock_x", int'(bus.locked_x), 24);
      chk("restart_x", int'(bus.x), 0);
      chk("restart_dir", int'(bus.dir), 1);
      strobes_off();
      tick();

      // asynchronous reset mid-sweep with a lock pending
      pulses(21);
      chk("mid_x", int'(bus.x), 84);
      bus.lock = 1;
      #2 reset = 1'b1;
      #1;
      model_reset();
      chk("async_x", int'(bus.x), 0);
      chk("async_lv", int'(bus.locked_valid), 0);
      @(posedge clk);
      #1;
      chk("async_lv_edge", int'(bus.locked_valid), 0);
      chk("async_y", int'(bus.y), 116);
      reset = 1'b0;
      bus.lock = 0;

      // erase forces black
      bus.colour_erase_enable = 1; bus.colour_in = 3'd7;
      #1;
      chk("erase", int'(bus.colour), 0);
      bus.colour_erase_enable = 0;
      #1;
      chk("no_erase", int'(bus.colour), 7);

      // randomised traffic
      for (int i = 0; i < 600; i++) begin
         bus.ld_x    = ($urandom_range(0, 9) < 7);
         bus.restart = ($urandom_range(0, 39) == 0);
         bus.lock    = ($urandom_range(0, 9) == 0);
         bus.ld_y    = ($urandom_range(0, 9) == 0);
         bus.curr_level = 6'($urandom_range(0, 63));
         if (bus.restart) bus.speed = 4'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0)
            bus.blk_cells = 4'($urandom_range(0, 15));
         bus.colour_in = 3'($urandom);
         bus.colour_erase_enable = ($urandom_range(0, 3) == 0);
         tick();
      end
      strobes_off();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
